// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the memory-stage SRAM controller:
//   - state_t           : controller FSM states
//   - BASE_ADDR_DEFAULT : byte address that maps to SRAM word 0
//   - SRAM_DW           : external SRAM data width (half-word)
//   - WAIT_CNT_W        : wait-counter width (WAIT_CYCLES is 0..7)
// -----------------------------------------------------------------------------
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;
  localparam int          SRAM_DW           = 16;
  localparam int          WAIT_CNT_W        = 3;

endpackage : mem_pkg

// File: rtl/sram_wait_counter.sv
// -----------------------------------------------------------------------------
// sram_wait_counter
// Times one SRAM half-word phase. Loaded with WAIT_CYCLES on the edge that
// enters a phase, counts down to zero and holds there; the phase's last cycle
// is the one in which the count is zero.
// Ports:
//   clk         : system clock, rising edge
//   rst         : synchronous active-high reset
//   i_load      : phase entry on the coming edge (reload the counter)
//   o_last      : current cycle is the last cycle of the phase
//   o_last_next : the cycle after the coming edge is the last of its phase
// -----------------------------------------------------------------------------
module sram_wait_counter
  import mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  output logic o_last,
  output logic o_last_next
);

  localparam logic [WAIT_CNT_W-1:0] LP_WAIT = WAIT_CNT_W'(WAIT_CYCLES);

  logic [WAIT_CNT_W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LP_WAIT;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_last      = (r_cnt == '0);
  // Lets the owner register its strobe one cycle ahead of the counter.
  assign o_last_next = i_load ? (LP_WAIT == '0) : (r_cnt <= WAIT_CNT_W'(1));

endmodule : sram_wait_counter

// File: rtl/mem_stage_sram_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stage_sram_ctrl
// Memory pipeline stage. Turns a 32-bit word load/store from the execution
// stage into two 16-bit SRAM transactions (low half, then high half), each
// held for WAIT_CYCLES+1 cycles, and stalls the pipeline via freeze until
// the access completes.
// Ports:
//   clk, rst               : clock and synchronous active-high reset
//   mem_read_en/write_en   : request from execution stage (write wins if both)
//   alu_res                : byte address; val_rm : store data
//   read_data              : last loaded word (held between loads)
//   ready                  : one-cycle pulse on access completion
//   freeze                 : combinational stall to upstream registers
//   sram_addr/dq_out/dq_oe : SRAM half-word address, write data, drive enable
//   sram_dq_in             : SRAM read data; sram_we_n : active-low strobe
// -----------------------------------------------------------------------------
module mem_stage_sram_ctrl
  import mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT,
  parameter int          WAIT_CYCLES = 1,
  parameter int          SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_read_en,
  input  logic               mem_write_en,
  input  logic [31:0]        alu_res,
  input  logic [31:0]        val_rm,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic               freeze,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [SRAM_DW-1:0] sram_dq_in,
  output logic               sram_we_n
);

  state_t             r_state;
  logic               r_is_wr;
  logic [31:0]        r_data;
  logic [SRAM_AW-1:0] r_lo_addr;
  logic [SRAM_DW-1:0] r_lo_half;
  logic [31:0]        r_read_data;
  logic               r_ready;
  logic [SRAM_AW-1:0] r_sram_addr;
  logic [SRAM_DW-1:0] r_sram_dq_out;
  logic               r_sram_dq_oe;
  logic               r_sram_we_n;

  logic               w_req;
  logic [31:0]        w_offset;
  logic [SRAM_AW-1:0] w_lo_addr;
  logic               w_unused_bits;
  logic               w_load;
  logic               w_last;
  logic               w_last_next;
  logic               w_freeze;
  logic               w_we_n_mid;

  assign w_req    = mem_read_en | mem_write_en;
  // Modular subtraction; word index is offset >> 2, low half-word is word*2.
  assign w_offset  = alu_res - BASE_ADDR;
  assign w_lo_addr = {w_offset[SRAM_AW:2], 1'b0};
  assign w_unused_bits = ^{w_offset[31:SRAM_AW+1], w_offset[1:0]};

  // Counter reloads on entry to LO (from IDLE) and to HI (from LO).
  assign w_load = ((r_state == IDLE) && w_req) || ((r_state == LO) && w_last);

  sram_wait_counter #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait_counter (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .o_last      (w_last),
    .o_last_next (w_last_next)
  );

  // Strobe for the next non-final phase cycle: low on writes except on the
  // phase's last cycle (only reached here when WAIT_CYCLES >= 1).
  assign w_we_n_mid = !(r_is_wr && !w_last_next);

  // NOTE: every combinational output gets a default first so no latch forms.
  always_comb begin
    w_freeze = 1'b0;
    unique case (r_state)
      IDLE:    w_freeze = w_req;
      LO, HI:  w_freeze = 1'b1;
      default: w_freeze = 1'b0;
    endcase
    // Reset aborts the access, so the stall is released in the reset cycle.
    if (rst) w_freeze = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_is_wr       <= 1'b0;
      r_data        <= '0;
      r_lo_addr     <= '0;
      r_lo_half     <= '0;
      r_read_data   <= '0;
      r_ready       <= 1'b0;
      r_sram_addr   <= '0;
      r_sram_dq_out <= '0;
      r_sram_dq_oe  <= 1'b0;
      r_sram_we_n   <= 1'b1;
    end else begin
      r_ready <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_req) begin
            r_state      <= LO;
            r_is_wr      <= mem_write_en;
            r_data       <= val_rm;
            r_lo_addr    <= w_lo_addr;
            r_sram_addr  <= w_lo_addr;
            r_sram_dq_oe <= mem_write_en;
            r_sram_we_n  <= !mem_write_en;
            if (mem_write_en) r_sram_dq_out <= val_rm[15:0];
          end
        end
        LO: begin
          if (w_last) begin
            r_state     <= HI;
            r_sram_addr <= r_lo_addr | SRAM_AW'(1);
            r_sram_we_n <= !r_is_wr;
            if (r_is_wr) r_sram_dq_out <= r_data[31:16];
            else         r_lo_half     <= sram_dq_in;
          end else begin
            r_sram_we_n <= w_we_n_mid;
          end
        end
        HI: begin
          if (w_last) begin
            r_state      <= DONE;
            r_ready      <= 1'b1;
            r_sram_we_n  <= 1'b1;
            r_sram_dq_oe <= 1'b0;
            if (!r_is_wr) r_read_data <= {sram_dq_in, r_lo_half};
          end else begin
            r_sram_we_n <= w_we_n_mid;
          end
        end
        default: begin
          // DONE: upstream advances on this edge.
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign read_data   = r_read_data;
  assign ready       = r_ready;
  assign freeze      = w_freeze;
  assign sram_addr   = r_sram_addr;
  assign sram_dq_out = r_sram_dq_out;
  assign sram_dq_oe  = r_sram_dq_oe;
  assign sram_we_n   = r_sram_we_n;

endmodule : mem_stage_sram_ctrl
